// File: rtl/not16_checker.sv
// Response checker for the Not16 gate: verifies vec_out == ~vec_in over N_VECTORS samples and reports a verdict.
// Optional feature: define NOT16_CHECKER_SIGNATURE_EN to add a MISR signature output over accepted vec_out values.
module not16_checker #(
  parameter int WIDTH     = 16,
  parameter int N_VECTORS = 4,
  localparam int CNT_W    = $clog2(N_VECTORS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] vec_in,
  input  logic [WIDTH-1:0] vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_in,
  output logic [WIDTH-1:0] first_fail_out
`ifdef NOT16_CHECKER_SIGNATURE_EN
  ,
  output logic [WIDTH-1:0] signature
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic             accept;
  logic             last_accept;
  logic             enter_run;
  logic             retire_match;
  logic [CNT_W-1:0] sample_idx;

  // Single-entry compare pipeline: captured at accept, retired one edge later.
  logic             pipe_vld;
  logic [WIDTH-1:0] pipe_in;
  logic [WIDTH-1:0] pipe_out;
  logic [CNT_W-1:0] pipe_idx;

  assign in_ready     = (state == RUN);
  assign busy         = (state == RUN) || (state == DRAIN);
  assign accept       = in_valid && in_ready;
  assign last_accept  = accept && (sample_idx == CNT_W'(N_VECTORS - 1));
  assign enter_run    = start && ((state == IDLE) || (state == DONE));
  assign retire_match = (pipe_out == ~pipe_in);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_accept) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      sample_idx     <= '0;
      pipe_vld       <= 1'b0;
      pipe_in        <= '0;
      pipe_out       <= '0;
      pipe_idx       <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_in  <= '0;
      first_fail_out <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      state <= state_nx;
      if (enter_run) begin
        sample_idx     <= '0;
        pipe_vld       <= 1'b0;
        pipe_in        <= '0;
        pipe_out       <= '0;
        pipe_idx       <= '0;
        pass_count     <= '0;
        fail_count     <= '0;
        first_fail_idx <= '0;
        first_fail_in  <= '0;
        first_fail_out <= '0;
        done           <= 1'b0;
        pass           <= 1'b0;
      end else begin
        pipe_vld <= accept;
        if (accept) begin
          pipe_in    <= vec_in;
          pipe_out   <= vec_out;
          pipe_idx   <= sample_idx;
          sample_idx <= sample_idx + CNT_W'(1);
        end
        if (pipe_vld) begin
          if (retire_match) begin
            pass_count <= pass_count + CNT_W'(1);
          end else begin
            fail_count <= fail_count + CNT_W'(1);
            if (fail_count == '0) begin
              first_fail_idx <= pipe_idx;
              first_fail_in  <= pipe_in;
              first_fail_out <= pipe_out;
            end
          end
        end
        // The last compare retires on this same edge, so fold it into the verdict.
        if (state == DRAIN) begin
          done <= 1'b1;
          pass <= (fail_count == '0) && (!pipe_vld || retire_match);
        end
      end
    end
  end

`ifdef NOT16_CHECKER_SIGNATURE_EN
  localparam logic [WIDTH-1:0] MISR_POLY = WIDTH'(16'hB400);

  always_ff @(posedge clk) begin
    if (reset || enter_run) begin
      signature <= '1;
    end else if (pipe_vld) begin
      signature <= {1'b0, signature[WIDTH-1:1]}
                   ^ (signature[0] ? MISR_POLY : '0)
                   ^ pipe_out;
    end
  end
`endif

endmodule

// File: tb/tb_not16_checker.sv
// Randomized scoreboard bench for not16_checker; expected verdicts come from a behavioural model of each run.
module tb_not16_checker;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset, start, in_valid;
  logic          in_ready, busy, done, pass;
  logic [W-1:0]  vec_in, vec_out;
  logic [CW-1:0] pass_count, fail_count, first_fail_idx;
  logic [W-1:0]  first_fail_in, first_fail_out;
`ifdef NOT16_CHECKER_SIGNATURE_EN
  logic [W-1:0]  signature;
`endif

  not16_checker #(.WIDTH(W), .N_VECTORS(N)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .vec_in(vec_in), .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
    .pass_count(pass_count), .fail_count(fail_count), .first_fail_idx(first_fail_idx),
    .first_fail_in(first_fail_in), .first_fail_out(first_fail_out)
`ifdef NOT16_CHECKER_SIGNATURE_EN
    , .signature(signature)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] pc, fc, fidx;
    logic [W-1:0]  fin, fout, sig;
    logic          ps;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] vin [N];
  logic [W-1:0] vout[N];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic         done_d   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Verdict of a whole run derived from the pairs alone.
  function automatic exp_t model();
    exp_t e;
    int   p = 0, f = 0;
    e.fidx = '0; e.fin = '0; e.fout = '0; e.sig = 16'hFFFF;
    for (int i = 0; i < N; i++) begin
      if (vout[i] == ~vin[i]) p++;
      else begin
        if (f == 0) begin e.fidx = CW'(i); e.fin = vin[i]; e.fout = vout[i]; end
        f++;
      end
      e.sig = (e.sig >> 1) ^ (e.sig[0] ? 16'hB400 : 16'h0000) ^ vout[i];
    end
    e.pc = CW'(p); e.fc = CW'(f); e.ps = (f == 0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (done && !done_d) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no verdict pending");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pass", 32'(pass), 32'(e.ps));
        chk("pass_count", 32'(pass_count), 32'(e.pc));
        chk("fail_count", 32'(fail_count), 32'(e.fc));
        chk("count_sum", 32'(pass_count) + 32'(fail_count), N);
        if (e.fc != 0) begin
          chk("first_fail_idx", 32'(first_fail_idx), 32'(e.fidx));
          chk("first_fail_in", 32'(first_fail_in), 32'(e.fin));
          chk("first_fail_out", 32'(first_fail_out), 32'(e.fout));
        end
`ifdef NOT16_CHECKER_SIGNATURE_EN
        chk("signature", 32'(signature), 32'(e.sig));
`endif
      end
    end
    done_d = done;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic gen(input int err_mask);
    for (int i = 0; i < N; i++) begin
      vin[i]  = W'($urandom);
      vout[i] = ~vin[i];
      if (err_mask[i]) vout[i] = ~vin[i] ^ W'($urandom_range(1, 65535));
    end
  endtask

  // Called at a negedge with the checker in IDLE or DONE.
  task automatic do_run(input int gap_pct, input bit start_mid, input bit start_last);
    int i = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_busy", 32'(busy), 1);
    chk("run_done_clr", 32'(done), 0);
    chk("run_cnt_clr", 32'(pass_count) + 32'(fail_count), 0);
    sb.push_back(model());
    while (i < N) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        vec_in   = W'($urandom);
        vec_out  = W'($urandom);
      end else begin
        in_valid = 1'b1;
        vec_in   = vin[i];
        vec_out  = vout[i];
        chk("in_ready_run", 32'(in_ready), 1);
      end
      if (start_mid && i == 1) start = 1'b1;
      if (start_last && i == N - 1 && in_valid) start = 1'b1;
      tick();
      start = 1'b0;
      if (in_valid) i++;
    end
    in_valid = 1'b0;
    chk("drain_busy", 32'(busy), 1);
    chk("drain_done", 32'(done), 0);
    chk("drain_ready", 32'(in_ready), 0);
    tick();
    chk("done_rise", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; vec_in = '0; vec_out = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_counts", 32'(pass_count) + 32'(fail_count) + 32'(first_fail_idx), 0);
    chk("rst_capture", 32'(first_fail_in) | 32'(first_fail_out), 0);

    // in_valid in IDLE must be ignored
    in_valid = 1'b1; vec_in = 16'h1111; vec_out = 16'h0000;
    chk("idle_ready", 32'(in_ready), 0);
    tick(); tick();
    in_valid = 1'b0;
    chk("idle_counts", 32'(pass_count) + 32'(fail_count), 0);

    // reset mid-run after two accepts aborts with no verdict
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; vec_in = 16'h0F0F; vec_out = 16'hF0F0; tick();
    vec_in = 16'h1234; vec_out = 16'h0000; tick();
    in_valid = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    chk("abort_ready", 32'(in_ready), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_counts", 32'(pass_count) + 32'(fail_count), 0);
    tick();
    chk("abort_idle", 32'(busy), 0);

    // all-correct, back-to-back
    vin[0] = 16'h1234; vin[1] = 16'hA5A5; vin[2] = 16'h0000; vin[3] = 16'hFFFF;
    for (int k = 0; k < N; k++) vout[k] = ~vin[k];
    do_run(0, 1'b0, 1'b0);

    // failures at samples 2 and 3; first one must be latched
    vin[0] = 16'h0001; vin[1] = 16'h8000; vin[2] = 16'h00FF; vin[3] = 16'h5555;
    vout[0] = 16'hFFFE; vout[1] = 16'h7FFF; vout[2] = 16'h0000; vout[3] = 16'h5555;
    do_run(0, 1'b0, 1'b0);

    // gaps plus start pulsed mid-run
    gen(0);
    do_run(50, 1'b1, 1'b0);

    // in_valid held in DONE must not change counts
    in_valid = 1'b1; vec_in = 16'hABCD; vec_out = 16'hABCD;
    for (int k = 0; k < 3; k++) begin
      chk("done_ready", 32'(in_ready), 0);
      tick();
      chk("done_counts", 32'(pass_count), N);
      chk("done_hold", 32'(done), 1);
    end
    in_valid = 1'b0;

    // start coinciding with the Nth accept is ignored
    gen(4'b0010);
    do_run(0, 1'b0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      gen(int'($urandom_range(0, 15)));
      do_run(int'($urandom_range(0, 60)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    tick(); tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
